scan_decoder: RTL

Parametrised, registered one-hot decoder with built-in address scanning: it decodes an external select in direct mode, or steps its own select through every output at a programmable dwell rate. It generalises the team's fixed 4x16 enable decoder to any width, adds continuous and single-sweep scan modes, and drives digit/row strobes for multiplexed displays and keypads in the lab designs.

---
 rtl/scan_decoder_pkg.sv | 35 +++
 rtl/onehot_dec.sv | 19 +
 rtl/scan_decoder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared mode encodings, FSM state constants and mode/state helpers for scan_decoder.
package scan_decoder_pkg;

   localparam int unsigned MODE_W = 2;

   localparam logic [MODE_W-1:0] MODE_DIRECT = 2'b00;
   localparam logic [MODE_W-1:0] MODE_SCAN   = 2'b01;
   localparam logic [MODE_W-1:0] MODE_SWEEP  = 2'b10;

   localparam int unsigned ST_W = 2;

   typedef logic [ST_W-1:0] state_t;

   localparam state_t ST_DIRECT     = 2'd0;
   localparam state_t ST_SCAN       = 2'd1;
   localparam state_t ST_SWEEP_IDLE = 2'd2;
   localparam state_t ST_SWEEP_RUN  = 2'd3;

   // Entry state for a mode value; the reserved encoding behaves as direct.
   function automatic state_t mode_entry(input logic [MODE_W-1:0] m);
      state_t s;
      case (m)
         MODE_SCAN:  s = ST_SCAN;
         MODE_SWEEP: s = ST_SWEEP_IDLE;
         default:    s = ST_DIRECT;
      endcase
      return s;
   endfunction

   // Mode family a state belongs to, expressed as that family's entry state.
   function automatic state_t state_family(input state_t s);
      return (s == ST_SWEEP_RUN) ? ST_SWEEP_IDLE : s;
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational select-to-one-hot decoder; out-of-range selects yield all zeros.
module onehot_dec #(
   parameter int unsigned SEL_W = 4,
   parameter int unsigned OUTS  = 16
) (
   input  logic             en,
   input  logic [SEL_W-1:0] sel,
   output logic [OUTS-1:0]  dec_c
);

   // Compare against every valid position so values >= OUTS never match.
   always_comb begin
      dec_c = '0;
      for (int unsigned i = 0; i < OUTS; i++) begin
         dec_c[i] = en && (sel == SEL_W'(i));
      end
   end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct select, continuous scan and single-sweep modes.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int unsigned SEL_W = 4,
   parameter int unsigned OUTS  = 16,
   parameter int unsigned DWELL = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic [SEL_W-1:0]  A,
   input  logic              start,
   output logic [OUTS-1:0]   D,
   output logic [SEL_W-1:0]  sel,
   output logic              busy,
   output logic              done,
   output logic              wrap
);

   localparam int unsigned CNT_W = $clog2(DWELL + 1);

   state_t            state;
   state_t            state_nx;
   state_t            req_state;
   logic [SEL_W-1:0]  sel_nx;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nx;
   logic              busy_nx;
   logic              done_nx;
   logic              wrap_nx;
   logic              show_nx;
   logic              last_dwell;
   logic              last_pos;
   logic [OUTS-1:0]   d_nx;

   // Terminal conditions of the dwell counter and the scan position.
   always_comb begin
      last_dwell = (cnt == CNT_W'(DWELL - 1));
      last_pos   = (sel == SEL_W'(OUTS - 1));
      req_state  = mode_entry(mode);
   end

   // Next-state and next-output logic; en low freezes everything but blanks D.
   always_comb begin
      state_nx = state;
      sel_nx   = sel;
      cnt_nx   = cnt;
      busy_nx  = busy;
      done_nx  = 1'b0;
      wrap_nx  = 1'b0;
      show_nx  = 1'b0;

      if (en) begin
         if (req_state != state_family(state)) begin
            // Mode change: restart in the new mode's entry state, aborting any sweep.
            state_nx = req_state;
            sel_nx   = '0;
            cnt_nx   = '0;
            busy_nx  = 1'b0;
            if (req_state == ST_DIRECT) begin
               sel_nx  = A;
               show_nx = 1'b1;
            end else if (req_state == ST_SCAN) begin
               show_nx = 1'b1;
            end
         end else begin
            case (state)
               ST_DIRECT: begin
                  sel_nx  = A;
                  cnt_nx  = '0;
                  show_nx = 1'b1;
               end
               ST_SCAN: begin
                  show_nx = 1'b1;
                  if (last_dwell) begin
                     cnt_nx = '0;
                     if (last_pos) begin
                        sel_nx  = '0;
                        wrap_nx = 1'b1;
                     end else begin
                        sel_nx = sel + SEL_W'(1);
                     end
                  end else begin
                     cnt_nx = cnt + CNT_W'(1);
                  end
               end
               ST_SWEEP_IDLE: begin
                  sel_nx = '0;
                  cnt_nx = '0;
                  if (start) begin
                     state_nx = ST_SWEEP_RUN;
                     busy_nx  = 1'b1;
                     show_nx  = 1'b1;
                  end
               end
               ST_SWEEP_RUN: begin
                  if (last_dwell) begin
                     cnt_nx = '0;
                     if (last_pos) begin
                        state_nx = ST_SWEEP_IDLE;
                        sel_nx   = '0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                     end else begin
                        sel_nx  = sel + SEL_W'(1);
                        show_nx = 1'b1;
                     end
                  end else begin
                     cnt_nx  = cnt + CNT_W'(1);
                     show_nx = 1'b1;
                  end
               end
               default: begin
                  state_nx = ST_DIRECT;
                  sel_nx   = '0;
                  cnt_nx   = '0;
                  busy_nx  = 1'b0;
               end
            endcase
         end
      end
   end

   // Decode the next select so D is registered alongside sel.
   onehot_dec #(
      .SEL_W (SEL_W),
      .OUTS  (OUTS)
   ) u_dec (
      .en    (show_nx),
      .sel   (sel_nx),
      .dec_c (d_nx)
   );

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_DIRECT;
         sel   <= '0;
         cnt   <= '0;
         D     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         state <= state_nx;
         sel   <= sel_nx;
         cnt   <= cnt_nx;
         D     <= d_nx;
         busy  <= busy_nx;
         done  <= done_nx;
         wrap  <= wrap_nx;
      end
   end

endmodule
